mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit: the producer side of the MEM/WB pipeline register.
//  - Takes the EX/MEM access: ALU address, store data, funct3, read/write enables.
//  - Runs a req/ready handshake with the data memory.
//  - Aligns and extends load data.
//  - Stalls the pipeline until the access completes.
//  - load_data feeds Data_R_in of the MEM/WB register.
// PARAMETERS
//  WIDTH        32   data/address width; only 32 is supported (4 byte lanes)
//  TIMEOUT_CYC  255  max BUSY cycles waiting for dmem_ready; 0 disables timeout (8-bit counter)
// PORTS
//  clk          in   1      system clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  mem_valid    in   1      MEM-stage instruction valid
//  mem_read     in   1      load request
//  mem_write    in   1      store request
//  funct3       in   3      000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr         in   WIDTH  byte address (ALU result)
//  store_data   in   WIDTH  rs2 value, LSB-justified
//  dmem_req     out  1      memory request, held until ready
//  dmem_we      out  1      1 = write
//  dmem_addr    out  WIDTH  word address {addr[31:2],2'b00}
//  dmem_wdata   out  WIDTH  lane-replicated store data
//  dmem_wstrb   out  4      byte write strobes (0 on reads)
//  dmem_ready   in   1      memory completes the access this cycle
//  dmem_rdata   in   WIDTH  read word, valid when dmem_ready=1
//  load_data    out  WIDTH  aligned, extended load result
//  stall        out  1      hold the pipeline (IF..MEM)
//  misalign     out  1      1-cycle pulse: misaligned or illegal access
//  bus_error    out  1      1-cycle pulse: timeout expired
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0, all outputs 0. Assertion mid-transaction
//    drops dmem_req immediately (asynchronously). The access is lost and no pulse is raised.
//  start = mem_valid & (mem_read ^ mem_write) & aligned & funct3 legal.
//    read&write both 1 -> no access, no stall, no pulse.
//  Alignment: H/HU need addr[0]=0. W needs addr[1:0]=0.
//    Stores accept only funct3 000/001/010. Any other funct3 is illegal.
//  FSM
//    IDLE: start -> BUSY. dmem_* registered from inputs. stall=1 combinationally this cycle.
//          valid access failing align/legality -> misalign=1 for this cycle, stay IDLE, stall=0.
//    BUSY: dmem_req=1. addr/we/wdata/wstrb stable. stall=1. Counter increments each cycle.
//          dmem_ready=1 -> capture rdata (loads), go RESP, clear counter.
//          Counter==TIMEOUT_CYC (nonzero) without ready -> bus_error=1, load_data=0, go RESP.
//    RESP: dmem_req=0, stall=0. Pipeline advances at this edge; MEM/WB captures load_data.
//          Next state is always IDLE. The same instruction is never re-issued.
//  Latency: stall high for 1 + N cycles, where N = BUSY cycles (>=1). Result is valid in RESP.
//  dmem_ready is ignored outside BUSY.
//  Store lanes, with o = addr[1:0]:
//    SB: wstrb = 4'b0001<<o, wdata = {4{sd[7:0]}}
//    SH: wstrb = 4'b0011<<o, wdata = {2{sd[15:0]}}
//    SW: wstrb = 4'b1111,    wdata = sd
//  Load extract:
//    byte = rdata[8*o +: 8]; half = rdata[16*o[1] +: 16]
//    LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
//  load_data holds its value until the next load completes. Stores and faults leave it unchanged,
//    except a timeout, which forces 0.
// TESTING
//  1. LW 0x100, ready after 2 BUSY cycles, rdata 0xDEADBEEF
//     -> stall high 3 cycles, then RESP; load_data=0xDEADBEEF, dmem_addr=0x100.
//  2. LB 0x103, rdata 0x80123456 -> load_data=0xFFFFFF80.
//     LBU at the same address -> 0x00000080.
//     LH 0x102 -> 0xFFFF8012.
//  3. SH 0x102, store_data 0x1234ABCD -> dmem_we=1, wstrb=4'b1100, wdata=0xABCDABCD.
//     load_data unchanged.
//  4. LW 0x102 and SH 0x101 -> misalign pulse 1 cycle, dmem_req never asserts, stall stays 0.
//  5. TIMEOUT_CYC=4, dmem_ready held 0 -> bus_error on the 4th BUSY cycle, req drops next cycle,
//     load_data=0.
//  6. reset_n low during BUSY -> dmem_req=0 and stall=0 with no clock edge.
//     After release, a new LW completes normally.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data-memory req/ready handshake,
// lane-aligns stores, extracts/extends loads and stalls the pipeline meanwhile.
module mem_stage_lsu #(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_valid,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    input  logic             dmem_ready,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] load_data,
    output logic             stall,
    output logic             misalign,
    output logic             bus_error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [7:0] TO_CYC = 8'(TIMEOUT_CYC);
    localparam logic       TO_EN  = (TIMEOUT_CYC != 0);

    logic [1:0]       r_state;
    logic [7:0]       r_cnt;
    logic             r_we;
    logic             r_is_ld;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [3:0]       r_wstrb;
    logic [WIDTH-1:0] r_load;

    logic             w_idle;
    logic             w_busy;
    logic             w_is_ld;
    logic             w_is_st;
    logic             w_access;
    logic             w_legal;
    logic             w_aligned;
    logic             w_start;
    logic             w_fault;
    logic [3:0]       w_wstrb;
    logic [WIDTH-1:0] w_wdata;
    logic [7:0]       w_cnt_nxt;
    logic             w_timeout;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_ext;

    assign w_idle   = (r_state == S_IDLE);
    assign w_busy   = (r_state == S_BUSY);
    assign w_is_ld  = mem_read & ~mem_write;
    assign w_is_st  = mem_write & ~mem_read;
    assign w_access = mem_valid & (mem_read ^ mem_write);

    // Unsigned load widths (BU/HU) have no store counterpart.
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b0;
        case (funct3)
            3'b000: begin w_legal = 1'b1;    w_aligned = 1'b1;               end
            3'b001: begin w_legal = 1'b1;    w_aligned = ~addr[0];           end
            3'b010: begin w_legal = 1'b1;    w_aligned = (addr[1:0] == 2'b00); end
            3'b100: begin w_legal = w_is_ld; w_aligned = 1'b1;               end
            3'b101: begin w_legal = w_is_ld; w_aligned = ~addr[0];           end
            default: begin w_legal = 1'b0;   w_aligned = 1'b0;               end
        endcase
    end

    assign w_start = w_idle & w_access & w_legal & w_aligned;
    assign w_fault = w_idle & w_access & ~(w_legal & w_aligned);

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = '0;
        if (w_is_st) begin
            case (funct3[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << addr[1:0];
                    w_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    w_wstrb = 4'b0011 << addr[1:0];
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = store_data;
                end
            endcase
        end
    end

    assign w_cnt_nxt = r_cnt + 8'd1;
    assign w_timeout = TO_EN & w_busy & ~dmem_ready & (w_cnt_nxt == TO_CYC);

    assign w_byte = 8'(dmem_rdata >> {r_off, 3'b000});
    assign w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_is_ld <= 1'b0;
            r_f3    <= 3'd0;
            r_off   <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= 4'b0000;
            r_load  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_BUSY;
                        r_cnt   <= 8'd0;
                        r_we    <= w_is_st;
                        r_is_ld <= w_is_ld;
                        r_f3    <= funct3;
                        r_off   <= addr[1:0];
                        r_addr  <= {addr[WIDTH-1:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_wstrb <= w_wstrb;
                    end
                end
                S_BUSY: begin
                    if (dmem_ready) begin
                        r_state <= S_RESP;
                        r_cnt   <= 8'd0;
                        if (r_is_ld) r_load <= w_ext;
                    end else if (w_timeout) begin
                        r_state <= S_RESP;
                        r_cnt   <= 8'd0;
                        r_load  <= '0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Reset gating keeps the combinational outputs quiet while reset is held.
    assign dmem_req   = w_busy;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_wstrb = r_wstrb;
    assign load_data  = r_load;
    assign stall      = reset_n & (w_busy | w_start);
    assign misalign   = reset_n & w_fault;
    assign bus_error  = reset_n & w_timeout;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus random accesses checked
// against a byte-lane reference model; a second instance covers the timeout.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_req, dmem_we, stall, misalign, bus_error;
    logic [31:0] dmem_addr, dmem_wdata, load_data;
    logic [3:0]  dmem_wstrb;

    logic        v2, rdy2;
    logic        req2, we2, stall2, mis2, berr2;
    logic [31:0] addr2, wdata2, load2;
    logic [3:0]  wstrb2;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_load = 32'd0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .load_data(load_data), .stall(stall),
        .misalign(misalign), .bus_error(bus_error)
    );

    mem_stage_lsu #(.TIMEOUT_CYC(4)) dut_to (
        .clk(clk), .reset_n(reset_n), .mem_valid(v2), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
        .dmem_req(req2), .dmem_we(we2), .dmem_addr(addr2),
        .dmem_wdata(wdata2), .dmem_wstrb(wstrb2), .dmem_ready(rdy2),
        .dmem_rdata(dmem_rdata), .load_data(load2), .stall(stall2),
        .misalign(mis2), .bus_error(berr2)
    );

    // Reference model: access size in bytes, legality, lane strobes/data, load value.
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 > 3'd5) return 0;
        if (wr && f3[2]) return 0;
        return (a % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << m_size(f3)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % m_size(f3)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rw);
        int sz = m_size(f3);
        longint v = (longint'(rw) >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 1);
        if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        return 32'(v);
    endfunction

    task automatic run_access(input string nm, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rw, input int nrdy);
        int nstall = 0;
        bit ok = m_legal(wr, f3, a);
        @(negedge clk);
        mem_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
        store_data = sd; dmem_ready = 1'b0; dmem_rdata = $urandom;
        #1;
        checks++;
        if (load_data !== exp_load) begin
            failures++; $display("FAIL %s idle_load got=%h exp=%h", nm, load_data, exp_load);
        end
        if (rd == wr || !ok) begin
            checks++;
            if ({dmem_req, stall, misalign} !== {2'b00, (rd != wr)}) begin
                failures++;
                $display("FAIL %s fault {req,stall,mis} got=%b exp=%b", nm,
                         {dmem_req, stall, misalign}, {2'b00, (rd != wr)});
            end
            @(negedge clk);
            mem_valid = 1'b0;
            #1;
            checks++;
            if ({dmem_req, stall, misalign} !== 3'b000) begin
                failures++;
                $display("FAIL %s after_fault got=%b exp=000", nm, {dmem_req, stall, misalign});
            end
            return;
        end
        checks++;
        if ({dmem_req, stall, misalign} !== 3'b010) begin
            failures++;
            $display("FAIL %s issue {req,stall,mis} got=%b exp=010", nm, {dmem_req, stall, misalign});
        end
        if (stall) nstall++;
        for (int k = 1; k <= nrdy; k++) begin
            @(negedge clk);
            dmem_ready = (k == nrdy);
            dmem_rdata = (k == nrdy) ? rw : $urandom;
            #1;
            if (stall) nstall++;
            checks++;
            if ({dmem_req, stall, bus_error} !== 3'b110 || dmem_addr !== {a[31:2], 2'b00} ||
                dmem_we !== wr || dmem_wstrb !== (wr ? m_strb(f3, a) : 4'b0000) ||
                (wr && dmem_wdata !== m_wdata(f3, sd))) begin
                failures++;
                $display("FAIL %s busy%0d req=%b stall=%b berr=%b addr=%h we=%b strb=%b wdata=%h exp addr=%h strb=%b wdata=%h",
                         nm, k, dmem_req, stall, bus_error, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
                         {a[31:2], 2'b00}, wr ? m_strb(f3, a) : 4'b0000, m_wdata(f3, sd));
            end
        end
        if (rd) exp_load = m_load(f3, a, rw);
        @(negedge clk);
        mem_valid = 1'b0;
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
        #1;
        checks++;
        if ({dmem_req, stall} !== 2'b00 || load_data !== exp_load) begin
            failures++;
            $display("FAIL %s resp req=%b stall=%b load=%h exp_load=%h", nm, dmem_req, stall,
                     load_data, exp_load);
        end
        checks++;
        if (nstall != 1 + nrdy) begin
            failures++; $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, nstall, 1 + nrdy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        addr = 32'd0; store_data = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
        v2 = 1'b0; rdy2 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, stall, misalign, bus_error} !== 5'd0 || dmem_addr !== 32'd0 ||
            dmem_wdata !== 32'd0 || dmem_wstrb !== 4'd0 || load_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_state ctl=%b addr=%h wdata=%h strb=%b load=%h exp all 0",
                     {dmem_req, dmem_we, stall, misalign, bus_error}, dmem_addr, dmem_wdata,
                     dmem_wstrb, load_data);
        end
        reset_n = 1'b1;
        exp_load = 32'd0;
    endtask

    task automatic test_lw_latency();
        run_access("lw_0x100", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    endtask

    task automatic test_load_extract();
        run_access("lb_0x103",  1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1);
        run_access("lbu_0x103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1);
        run_access("lh_0x102",  1, 0, 3'b001, 32'h102, 32'h0, 32'h80123456, 3);
        checks++;
        if (load_data !== 32'hFFFF8012) begin
            failures++; $display("FAIL lh_const got=%h exp=FFFF8012", load_data);
        end
    endtask

    task automatic test_store_lanes();
        run_access("sh_0x102", 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1);
        run_access("sb_0x101", 0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 2);
        run_access("sw_0x104", 0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 1);
        checks++;
        if (load_data !== 32'hFFFF8012) begin
            failures++; $display("FAIL store_keeps_load got=%h exp=FFFF8012", load_data);
        end
    endtask

    task automatic test_misalign();
        run_access("lw_0x102", 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1);
        run_access("sh_0x101", 0, 1, 3'b001, 32'h101, 32'h0, 32'h0, 1);
        run_access("sbu_ill",  0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 1);
        run_access("f3_011",   1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1);
        run_access("rw_both",  1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            logic [1:0] op = 2'($urandom);
            run_access("rand", op[0], op[1], 3'($urandom), $urandom, $urandom, $urandom,
                       int'($urandom_range(1, 4)));
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        v2 = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h200;
        rdy2 = 1'b0;
        @(negedge clk);
        rdy2 = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        rdy2 = 1'b0; v2 = 1'b0;
        #1;
        checks++;
        if (load2 !== 32'h12345678) begin
            failures++; $display("FAIL to_preload got=%h exp=12345678", load2);
        end
        @(negedge clk);
        v2 = 1'b1; addr = 32'h204;
        #1;
        checks++;
        if (stall2 !== 1'b1) begin
            failures++; $display("FAIL to_issue stall got=%b exp=1", stall2);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({req2, stall2, berr2} !== {2'b11, (k == 4)}) begin
                failures++;
                $display("FAIL to_busy%0d {req,stall,berr} got=%b exp=%b", k,
                         {req2, stall2, berr2}, {2'b11, (k == 4)});
            end
        end
        @(negedge clk);
        v2 = 1'b0;
        #1;
        checks++;
        if ({req2, stall2, berr2} !== 3'b000 || load2 !== 32'd0) begin
            failures++;
            $display("FAIL to_resp {req,stall,berr}=%b load=%h exp 000 / 0", {req2, stall2, berr2}, load2);
        end
    endtask

    task automatic test_reset_midbusy();
        @(negedge clk);
        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
        dmem_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (dmem_req !== 1'b1) begin
            failures++; $display("FAIL rst_pre_busy req got=%b exp=1", dmem_req);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, stall, misalign, bus_error} !== 4'b0000 || load_data !== 32'd0) begin
            failures++;
            $display("FAIL rst_async {req,stall,mis,berr}=%b load=%h exp 0000 / 0",
                     {dmem_req, stall, misalign, bus_error}, load_data);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        reset_n = 1'b1;
        exp_load = 32'd0;
        run_access("lw_after_rst", 1, 0, 3'b010, 32'h304, 32'h0, 32'hA5A55A5A, 1);
    endtask

    initial begin
        test_reset();
        test_lw_latency();
        test_load_extract();
        test_store_lanes();
        test_misalign();
        test_random();
        test_timeout();
        test_reset_midbusy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
